// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared types and constants for the elastic inter-stage pipeline register.
//   state_t      : occupancy state of a two-entry stage (EMPTY, ONE, FULL)
//   EXM_*        : bit positions of the EX/MEM control bundle
//   EXM_*_LSB/W  : field layout of the EX/MEM data bundle, packed from bit 0 up
// Optional feature macro used by the top level: PIPE_STAGE_PERF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // EX/MEM control bundle bit positions
    localparam int EXM_MEMWR    = 0;
    localparam int EXM_BRANCH   = 1;
    localparam int EXM_JUMP     = 2;
    localparam int EXM_MEMTOREG = 3;
    localparam int EXM_REGWR    = 4;
    localparam int EXM_CTRL_W   = 5;

    // EX/MEM data bundle field widths
    localparam int EXM_RW_W    = 5;
    localparam int EXM_DI_W    = 32;
    localparam int EXM_ADDR_W  = 32;
    localparam int EXM_JTARG_W = 30;
    localparam int EXM_BTARG_W = 30;

    // EX/MEM data bundle field offsets (LSB of each field)
    localparam int EXM_RW_LSB    = 0;
    localparam int EXM_DI_LSB    = EXM_RW_LSB + EXM_RW_W;
    localparam int EXM_ADDR_LSB  = EXM_DI_LSB + EXM_DI_W;
    localparam int EXM_OVF       = EXM_ADDR_LSB + EXM_ADDR_W;
    localparam int EXM_ZERO      = EXM_OVF + 1;
    localparam int EXM_JTARG_LSB = EXM_ZERO + 1;
    localparam int EXM_BTARG_LSB = EXM_JTARG_LSB + EXM_JTARG_W;
    localparam int EXM_DATA_W    = EXM_BTARG_LSB + EXM_BTARG_W;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
// One storage entry of a pipeline stage: data bundle, control bundle, valid.
// Ports:
//   clk, rst_n      : stage clock (state changes on the falling edge), async active-low reset
//   load            : capture in_data/in_ctrl and mark the entry valid
//   clear           : invalidate the entry and zero its control; wins over load
//   in_data/in_ctrl : values captured on load
//   valid/data/ctrl : stored entry; ctrl is zero whenever valid is zero
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Data is left untouched on clear: a dead entry's data is don't-care,
    // but its control must read as a bubble.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            ctrl  <= in_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Elastic inter-stage pipeline register with valid/ready handshake, flush to
// bubble and an optional skid entry (DEPTH = 2) so downstream back-pressure
// never reaches in_ready combinationally.
// Ports:
//   clk, rst_n            : stage clock (falling-edge updates), async active-low reset
//   flush                 : synchronous kill of every held entry
//   in_valid/in_ready     : upstream handshake
//   in_data/in_ctrl       : upstream bundles
//   out_valid/out_ready   : downstream handshake
//   out_data/out_ctrl     : registered bundles; out_ctrl is 0 while out_valid is 0
//   occupancy             : number of held entries (0..DEPTH)
//   stall_cnt/bubble_cnt  : performance counters, present only with PIPE_STAGE_PERF_EN
// Optional feature macro: PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 5,
    parameter int DEPTH  = 2
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic              ready_en;
    logic              accept;
    logic              consume;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_src_data;
    logic [CTRL_W-1:0] main_src_ctrl;

    // in_ready stays low while in reset and comes up on the first falling
    // edge after release.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .in_data (main_src_data),
        .in_ctrl (main_src_ctrl),
        .valid   (out_valid),
        .data    (out_data),
        .ctrl    (out_ctrl)
    );

    generate
        if (DEPTH == 1) begin : g_plain
            // Plain stall register: ready follows out_ready combinationally.
            assign in_ready      = ready_en & (~out_valid | out_ready);
            assign main_src_data = in_data;
            assign main_src_ctrl = in_ctrl;
            assign main_load     = accept & ~flush;
            assign main_clear    = flush | (consume & ~accept);
            assign occupancy     = {1'b0, out_valid};
        end else begin : g_skid
            state_t            state;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (skid_load),
                .clear   (skid_clear),
                .in_data (in_data),
                .in_ctrl (in_ctrl),
                .valid   (skid_valid),
                .data    (skid_data),
                .ctrl    (skid_ctrl)
            );

            // in_ready depends only on registered state, never on out_ready.
            assign in_ready  = ready_en & (state != FULL);
            assign occupancy = 2'(state);

            // When the skid holds an entry it is the older one waiting behind
            // main, so main refills from it to keep strict ordering.
            assign main_src_data = skid_valid ? skid_data : in_data;
            assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

            always_comb begin
                main_load  = 1'b0;
                main_clear = 1'b0;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                if (flush) begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state)
                        EMPTY: main_load = accept;
                        ONE: begin
                            if (accept && consume) begin
                                main_load = 1'b1;
                            end else if (accept) begin
                                skid_load = 1'b1;
                            end else if (consume) begin
                                main_clear = 1'b1;
                            end
                        end
                        FULL: begin
                            if (consume) begin
                                main_load  = 1'b1;
                                skid_clear = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // Occupancy state; flush overrides any same-cycle transfer.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= EMPTY;
                end else if (flush) begin
                    state <= EMPTY;
                end else begin
                    case (state)
                        EMPTY: if (accept) state <= ONE;
                        ONE: begin
                            if (accept && !consume) begin
                                state <= FULL;
                            end else if (!accept && consume) begin
                                state <= EMPTY;
                            end
                        end
                        FULL: if (consume) state <= ONE;
                        default: state <= EMPTY;
                    endcase
                end
            end
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; flush does not clear them.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!out_valid && !flush && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg (DEPTH = 2). Inputs change 1 time unit
// after a falling edge; outputs are sampled 1 time unit after the next one.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [4:0]   in_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_ctrl;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]  stall_cnt;
    logic [15:0]  bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [4:0] c,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset values
        #3;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_ctrl", out_ctrl, 0);
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        #9 rst_n = 1'b1;
        tick;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Single push with downstream ready
        applyStimulus(1'b1, 128'hCAFE_0000_0000_0000_0000_0000_0000_1234, 5'b10001, 1'b1, 1'b0);
        tick;
        checkOutput("push_valid", out_valid, 1);
        checkOutput("push_ctrl", out_ctrl, 5'b10001);
        checkOutput("push_data", out_data, 128'hCAFE_0000_0000_0000_0000_0000_0000_1234);
        checkOutput("push_occ", occupancy, 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick;
        checkOutput("drain_valid", out_valid, 0);
        checkOutput("drain_ctrl", out_ctrl, 0);
        checkOutput("drain_occ", occupancy, 0);

        // Back-pressure fill: A, B held, C waits, then all emerge in order
        applyStimulus(1'b1, 128'hA, 5'd1, 1'b0, 1'b0);
        tick;
        checkOutput("bp_occ_a", occupancy, 1);
        applyStimulus(1'b1, 128'hB, 5'd2, 1'b0, 1'b0);
        tick;
        checkOutput("bp_occ_full", occupancy, 2);
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_head_a", out_data, 128'hA);
        applyStimulus(1'b1, 128'hC, 5'd3, 1'b0, 1'b0);
        tick;
        checkOutput("bp_c_held_occ", occupancy, 2);
        checkOutput("bp_c_held_head", out_data, 128'hA);
        checkOutput("bp_c_held_ctrl", out_ctrl, 5'd1);
        applyStimulus(1'b1, 128'hC, 5'd3, 1'b1, 1'b0);
        tick;
        checkOutput("bp_out_b", out_data, 128'hB);
        checkOutput("bp_out_b_ctrl", out_ctrl, 5'd2);
        checkOutput("bp_occ_after_b", occupancy, 1);
        tick;
        checkOutput("bp_out_c", out_data, 128'hC);
        checkOutput("bp_out_c_ctrl", out_ctrl, 5'd3);
        checkOutput("bp_out_c_valid", out_valid, 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick;
        checkOutput("bp_empty", out_valid, 0);

        // Flush while FULL with a simultaneous input
        applyStimulus(1'b1, 128'hD, 5'd4, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, 128'hE, 5'd5, 1'b0, 1'b0);
        tick;
        checkOutput("fl_pre_occ", occupancy, 2);
        applyStimulus(1'b1, 128'hF, 5'd6, 1'b0, 1'b1);
        tick;
        checkOutput("fl_occ", occupancy, 0);
        checkOutput("fl_valid", out_valid, 0);
        checkOutput("fl_ctrl", out_ctrl, 0);
        checkOutput("fl_in_ready", in_ready, 1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick;
        checkOutput("fl_no_capture_valid", out_valid, 0);
        checkOutput("fl_no_capture_occ", occupancy, 0);

        // Full throughput
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 128'(100 + i), 5'(i + 1), 1'b1, 1'b0);
            tick;
            checkOutput("tp_valid", out_valid, 1);
            checkOutput("tp_data", out_data, 128'(100 + i));
            checkOutput("tp_in_ready", in_ready, 1);
            checkOutput("tp_occ", occupancy, 1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick;
        checkOutput("tp_drain", out_valid, 0);

        // Asynchronous reset mid-stream while FULL
        applyStimulus(1'b1, 128'h77, 5'd7, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, 128'h88, 5'd8, 1'b0, 1'b0);
        tick;
        checkOutput("ar_pre_occ", occupancy, 2);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", out_valid, 0);
        checkOutput("ar_data", out_data, 0);
        checkOutput("ar_ctrl", out_ctrl, 0);
        checkOutput("ar_occ", occupancy, 0);
        #2 rst_n = 1'b1;
        tick;
        checkOutput("ar_in_ready", in_ready, 1);

`ifdef PIPE_STAGE_PERF_EN
        // Counters from a fresh reset: 2 empty edges, 1 push edge (also empty),
        // 3 stalled edges, then a flush edge that stalls and an empty edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("perf_rst_stall", stall_cnt, 0);
        checkOutput("perf_rst_bubble", bubble_cnt, 0);
        #2 rst_n = 1'b1;
        tick;
        tick;
        checkOutput("perf_bubble_2", bubble_cnt, 2);
        applyStimulus(1'b1, 128'h99, 5'd9, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick;
        tick;
        tick;
        checkOutput("perf_stall_3", stall_cnt, 3);
        checkOutput("perf_bubble_3", bubble_cnt, 3);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick;
        checkOutput("perf_flush_stall", stall_cnt, 4);
        checkOutput("perf_flush_bubble", bubble_cnt, 3);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick;
        checkOutput("perf_after_flush_bubble", bubble_cnt, 4);
        checkOutput("perf_after_flush_stall", stall_cnt, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
